// File: rtl/sha256_padder_if.sv
// Handshake bundle between a message source, the SHA-256 padder and the
// downstream hash core: word-in stream on one side, 512-bit blocks on the other.
interface sha256_padder_if;
  logic [31:0]  data_in;
  logic         valid_in;
  logic         last_in;
  logic [1:0]   bytes_in;
  logic         ready_out;
  logic [511:0] block_out;
  logic         block_valid_out;
  logic         block_ready_in;
  logic         first_out;
  logic         last_out;
  logic [1:0]   FSM_state_out;

  modport master (
    output data_in, valid_in, last_in, bytes_in, block_ready_in,
    input  ready_out, block_out, block_valid_out, first_out, last_out, FSM_state_out
  );

  modport slave (
    input  data_in, valid_in, last_in, bytes_in, block_ready_in,
    output ready_out, block_out, block_valid_out, first_out, last_out, FSM_state_out
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_padder (
  input  logic            CLK,
  input  logic            RST,
  sha256_padder_if.slave  bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [31:0]  r_buf [16];
  logic [3:0]   r_widx;
  logic [63:0]  r_bitlen;
  logic         r_mark_done;
  logic         r_pad_mode;
  logic         r_final;
  logic         r_first;

  logic [3:0]   w_widx_nxt;
  logic [63:0]  w_bitlen_nxt;
  logic         w_mark_nxt;
  logic         w_pad_nxt;
  logic         w_final_nxt;
  logic         w_first_nxt;
  logic         w_wr_en;
  logic [31:0]  w_wr_data;

  logic         r_ready;
  logic         r_block_valid;
  logic         r_first_o;
  logic         r_last_o;
  logic [511:0] w_block;

  // Next-state, flag updates and the single buffer write port
  always_comb begin
    w_state_nxt  = r_state;
    w_widx_nxt   = r_widx;
    w_bitlen_nxt = r_bitlen;
    w_mark_nxt   = r_mark_done;
    w_pad_nxt    = r_pad_mode;
    w_final_nxt  = r_final;
    w_first_nxt  = r_first;
    w_wr_en      = 1'b0;
    w_wr_data    = 32'h0000_0000;
    case (r_state)
      COLLECT: begin
        if (bus.valid_in) begin
          w_wr_en    = 1'b1;
          w_widx_nxt = r_widx + 4'd1;
          if (bus.last_in) begin
            w_pad_nxt = 1'b1;
            // A partial last word carries the 0x80 marker right after its data
            case (bus.bytes_in)
              2'd1: begin
                w_wr_data    = {bus.data_in[31:24], 8'h80, 16'h0000};
                w_mark_nxt   = 1'b1;
                w_bitlen_nxt = r_bitlen + 64'd8;
              end
              2'd2: begin
                w_wr_data    = {bus.data_in[31:16], 8'h80, 8'h00};
                w_mark_nxt   = 1'b1;
                w_bitlen_nxt = r_bitlen + 64'd16;
              end
              2'd3: begin
                w_wr_data    = {bus.data_in[31:8], 8'h80};
                w_mark_nxt   = 1'b1;
                w_bitlen_nxt = r_bitlen + 64'd24;
              end
              default: begin
                w_wr_data    = bus.data_in;
                w_mark_nxt   = 1'b0;
                w_bitlen_nxt = r_bitlen + 64'd32;
              end
            endcase
            w_state_nxt = (r_widx == 4'd15) ? EMIT : PAD;
          end else begin
            w_wr_data    = bus.data_in;
            w_bitlen_nxt = r_bitlen + 64'd32;
            w_state_nxt  = (r_widx == 4'd15) ? EMIT : COLLECT;
          end
          if (r_widx == 4'd15) begin
            w_final_nxt = 1'b0;
          end else begin
            w_final_nxt = r_final;
          end
        end else begin
          w_wr_en = 1'b0;
        end
      end
      PAD: begin
        w_wr_en    = 1'b1;
        w_widx_nxt = r_widx + 4'd1;
        if (!r_mark_done) begin
          w_wr_data  = 32'h8000_0000;
          w_mark_nxt = 1'b1;
        end else if (r_widx == 4'd14) begin
          w_wr_data   = r_bitlen[63:32];
          w_final_nxt = 1'b1;
        end else if ((r_widx == 4'd15) && r_final) begin
          w_wr_data = r_bitlen[31:0];
        end else begin
          w_wr_data = 32'h0000_0000;
        end
        if (r_widx == 4'd15) begin
          w_state_nxt = EMIT;
        end else begin
          w_state_nxt = PAD;
        end
      end
      EMIT: begin
        if (bus.block_ready_in) begin
          w_widx_nxt  = 4'd0;
          w_first_nxt = 1'b0;
          if (r_final) begin
            w_state_nxt  = COLLECT;
            w_bitlen_nxt = 64'd0;
            w_pad_nxt    = 1'b0;
            w_final_nxt  = 1'b0;
            w_first_nxt  = 1'b1;
          end else if (r_pad_mode) begin
            w_state_nxt = PAD;
          end else begin
            w_state_nxt = COLLECT;
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // State, buffer and flag registers; outputs are registered from next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= COLLECT;
      r_widx        <= 4'd0;
      r_bitlen      <= 64'd0;
      r_mark_done   <= 1'b0;
      r_pad_mode    <= 1'b0;
      r_final       <= 1'b0;
      r_first       <= 1'b1;
      r_ready       <= 1'b1;
      r_block_valid <= 1'b0;
      r_first_o     <= 1'b0;
      r_last_o      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= 32'h0000_0000;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_widx        <= w_widx_nxt;
      r_bitlen      <= w_bitlen_nxt;
      r_mark_done   <= w_mark_nxt;
      r_pad_mode    <= w_pad_nxt;
      r_final       <= w_final_nxt;
      r_first       <= w_first_nxt;
      r_ready       <= (w_state_nxt == COLLECT);
      r_block_valid <= (w_state_nxt == EMIT);
      r_first_o     <= (w_state_nxt == EMIT) && w_first_nxt;
      r_last_o      <= (w_state_nxt == EMIT) && w_final_nxt;
      if (w_wr_en) begin
        r_buf[r_widx] <= w_wr_data;
      end
    end
  end

  // Flatten the word buffer, word 0 in the most significant position
  always_comb begin
    w_block = 512'd0;
    for (int i = 0; i < 16; i++) begin
      w_block[511 - 32*i -: 32] = r_buf[i];
    end
  end

  assign bus.ready_out       = r_ready;
  assign bus.block_out       = w_block;
  assign bus.block_valid_out = r_block_valid;
  assign bus.first_out       = r_first_o;
  assign bus.last_out        = r_last_o;
  assign bus.FSM_state_out   = r_state;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder: a byte-level SHA-256 padding model
// predicts every block and its first/last flags.
module tb_sha256_padder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_padder_if bus();
  sha256_padder dut (.CLK(clk), .RST(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_mode = 0;
  int acc_cyc = 0;
  int exp_lat = 0;
  bit lat_armed = 1'b0;

  logic [511:0] exp_blk_q[$];
  logic [1:0]   exp_fl_q[$];
  logic [511:0] last_blk;
  logic [1:0]   last_fl;
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [511:0] prev_blk;
  logic [1:0]   prev_fl;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: standard SHA-256 padding of a byte string, cut into 64-byte blocks
  task automatic model(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] blk;
    int nb;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = 512'd0;
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      exp_blk_q.push_back(blk);
      exp_fl_q.push_back({(b == 0), (b == nb - 1)});
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready driver plus block monitor
  always @(negedge clk) begin
    case (ready_mode)
      0:       bus.block_ready_in = 1'b1;
      1:       bus.block_ready_in = ($urandom_range(0, 3) != 0);
      default: bus.block_ready_in = 1'b0;
    endcase
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_block", bus.block_out, prev_blk);
        check("hold_flags", {bus.first_out, bus.last_out}, prev_fl);
      end
      if (bus.block_valid_out) begin
        check("ready_in_emit", bus.ready_out, 1'b0);
        check("state_emit", bus.FSM_state_out, 2'd2);
        if (!prev_valid && lat_armed) begin
          check("latency", cyc - acc_cyc + 1, exp_lat);
          lat_armed = 1'b0;
        end
        if (bus.block_ready_in) begin
          if (exp_blk_q.size() == 0) begin
            check("extra_block", exp_blk_q.size(), 1);
          end else begin
            last_blk = bus.block_out;
            last_fl  = {bus.first_out, bus.last_out};
            check("block", bus.block_out, exp_blk_q.pop_front());
            check("first_last", {bus.first_out, bus.last_out}, exp_fl_q.pop_front());
          end
        end
      end else begin
        check("flags_idle", {bus.first_out, bus.last_out}, 2'b00);
      end
      prev_valid = bus.block_valid_out;
      prev_ready = bus.block_ready_in;
      prev_blk   = bus.block_out;
      prev_fl    = {bus.first_out, bus.last_out};
    end
  end

  task automatic send_bytes(input logic [7:0] m[$], input int gap_pct);
    int n, nw, to;
    logic [31:0] w;
    logic [7:0] bv;
    n  = m.size();
    nw = (n + 3) / 4;
    model(m);
    @(negedge clk);
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < 4; b++) begin
        bv = (4*k + b < n) ? m[4*k + b] : 8'($urandom_range(0, 255));
        w[31 - 8*b -: 8] = bv;
      end
      if ($urandom_range(0, 99) < gap_pct) begin
        bus.valid_in = 1'b0;
        @(negedge clk);
      end
      bus.data_in  = w;
      bus.valid_in = 1'b1;
      bus.last_in  = (k == nw - 1);
      bus.bytes_in = (k == nw - 1) ? 2'(n % 4) : 2'($urandom_range(0, 3));
      to = 0;
      while (!bus.ready_out && to < 400) begin
        @(negedge clk);
        to++;
      end
      if (to >= 400) begin
        check("accept_timeout", to, 0);
        bus.valid_in = 1'b0;
        return;
      end
      @(posedge clk);
      if (k == nw - 1) begin
        acc_cyc   = cyc + 1;
        exp_lat   = 16 - (k % 16);
        lat_armed = ((k % 16) != 15);
      end
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  task automatic rand_msg(input int len, output logic [7:0] m[$]);
    m.delete();
    for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drain();
    int to = 0;
    while (exp_blk_q.size() != 0 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check("drain", exp_blk_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_blk_q.delete();
    exp_fl_q.delete();
    lat_armed = 1'b0;
    @(negedge clk);
    check("rst_state", bus.FSM_state_out, 2'd0);
    check("rst_ready", bus.ready_out, 1'b1);
    check("rst_valid", bus.block_valid_out, 1'b0);
    check("rst_flags", {bus.first_out, bus.last_out}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] m[$];
    logic [7:0] abc[$];
    int to;
    int lens[12] = '{55, 56, 57, 60, 61, 63, 64, 65, 119, 120, 128, 4};
    abc = {8'h61, 8'h62, 8'h63};
    bus.data_in  = 32'h0;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.bytes_in = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_block", bus.block_out, 512'd0);
    do_reset();

    // "abc"
    ready_mode = 0;
    send_bytes(abc, 0);
    drain();
    check("abc_block", last_blk, {32'h61626380, 448'd0, 32'h00000018});
    check("abc_flags", last_fl, 2'b11);

    // 56 and 64 byte boundaries
    rand_msg(56, m); send_bytes(m, 0); drain();
    check("b56_flags", last_fl, 2'b01);
    rand_msg(64, m); send_bytes(m, 0); drain();
    check("b64_last", last_blk, {32'h80000000, 448'd0, 32'h00000200});

    // Stall in EMIT with the next message already waiting
    ready_mode = 2;
    fork
      begin
        send_bytes(abc, 0);
        rand_msg(10, m);
        send_bytes(m, 0);
      end
      begin
        to = 0;
        while (!bus.block_valid_out && to < 100) begin
          @(negedge clk);
          to++;
        end
        check("stall_reach_emit", bus.block_valid_out, 1'b1);
        repeat (10) @(negedge clk);
        ready_mode = 0;
      end
    join
    drain();

    // Reset during PAD of a 3-word message, then "abc"
    rand_msg(12, m);
    send_bytes(m, 0);
    repeat (2) @(negedge clk);
    check("mid_pad_state", bus.FSM_state_out, 2'd1);
    do_reset();
    send_bytes(abc, 0);
    drain();
    check("post_rst_abc", last_blk, {32'h61626380, 448'd0, 32'h00000018});
    check("post_rst_flags", last_fl, 2'b11);

    // Reset during EMIT
    ready_mode = 2;
    rand_msg(5, m);
    send_bytes(m, 0);
    to = 0;
    while (!bus.block_valid_out && to < 100) begin
      @(negedge clk);
      to++;
    end
    do_reset();
    ready_mode = 0;

    // Back-to-back one-byte messages
    m = {8'h61};
    send_bytes(m, 0);
    drain();
    check("one_byte_a", last_blk, {32'h61800000, 448'd0, 32'h00000008});
    check("one_byte_a_fl", last_fl, 2'b11);
    send_bytes(m, 0);
    drain();
    check("one_byte_b", last_blk, {32'h61800000, 448'd0, 32'h00000008});
    check("one_byte_b_fl", last_fl, 2'b11);

    // Boundary lengths and random traffic with random downstream backpressure
    ready_mode = 1;
    foreach (lens[i]) begin
      rand_msg(lens[i], m);
      send_bytes(m, 10);
    end
    for (int i = 0; i < 25; i++) begin
      rand_msg($urandom_range(1, 140), m);
      send_bytes(m, 20);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
